// File: rtl/inst_issue_buffer.sv
// inst_issue_buffer
//   Instruction queue between fetch and decode. Fetched instruction/PC pairs
//   are held in a circular buffer; the two oldest entries are presented to
//   decode. When INST_ISSUE_BUFFER_DUAL_ISSUE_EN is defined, both head entries
//   are pre-decoded and out1_valid flags whether the pair may issue together.
//   Without the macro the block is a single-issue skid FIFO: out1_valid is 0
//   and out_take=2 consumes a single entry.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   in_valid/in_ready  fetch handshake (in_ready = count < DEPTH)
//   in_inst, in_pc     instruction word and its address
//   flush              discard all contents; overrides write and take
//   out0_*             oldest entry (valid when count >= 1)
//   out1_*             second-oldest entry; out1_valid only when pairable
//   out_take           entries consumed by decode this cycle (0..2)
//   count              current occupancy
module inst_issue_buffer #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [31:0]      in_pc,
    input  logic             flush,
    output logic             out0_valid,
    output logic [31:0]      out0_inst,
    output logic [31:0]      out0_pc,
    output logic             out1_valid,
    output logic [31:0]      out1_inst,
    output logic [31:0]      out1_pc,
    input  logic [1:0]       out_take,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_q [DEPTH];
    logic [31:0]      inst_d [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [31:0]      pc_d   [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PTR_W-1:0] head1;
    logic             pair_ok;
    logic [1:0]       avail;
    logic [1:0]       take_eff;
    logic             wr_en;

`ifdef INST_ISSUE_BUFFER_DUAL_ISSUE_EN
    // Control transfer: J, JAL, BEQ/BNE/BLEZ/BGTZ, REGIMM, JR/JALR.
    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
        logic r;
        r = 1'b0;
        case (op)
            6'b000001, 6'b000010, 6'b000011,
            6'b000100, 6'b000101, 6'b000110, 6'b000111: r = 1'b1;
            6'b000000: r = (fn == 6'b001000) || (fn == 6'b001001);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

    // Destination register; 0 means no destination.
    function automatic logic [4:0] dest_of(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] d;
        d = '0;
        if (op == 6'b000000)
            d = rd;
        else if (op == 6'b000011)
            d = 5'd31;
        else if (op == 6'b000001 && rt[4])
            d = 5'd31;
        else if (op[5:3] == 3'b001 || op[5:3] == 3'b100)
            d = rt;
        return d;
    endfunction

    // Coprocessor ops, SPECIAL2, CACHE and SPECIAL system/HI-LO ops must issue alone.
    function automatic logic is_serial(input logic [5:0] op, input logic [5:0] fn);
        logic r;
        r = 1'b0;
        case (op)
            6'b010000, 6'b010001, 6'b010011, 6'b011100, 6'b101111: r = 1'b1;
            6'b000000: begin
                case (fn)
                    6'b001100, 6'b001101, 6'b001111,
                    6'b010000, 6'b010001, 6'b010010, 6'b010011,
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: r = 1'b1;
                    default: r = 1'b0;
                endcase
            end
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [31:0] s0, s1;
    logic [4:0]  dest0, dest1;
    logic        hazard;

    always_comb begin
        s0      = inst_q[head_q];
        s1      = inst_q[head1];
        dest0   = dest_of(s0[31:26], s0[20:16], s0[15:11]);
        dest1   = dest_of(s1[31:26], s1[20:16], s1[15:11]);
        hazard  = (dest0 != 5'd0) &&
                  ((dest0 == s1[25:21]) || (dest0 == s1[20:16]) || (dest0 == dest1));
        pair_ok = (count_q >= CNT_W'(2))
                  && !is_branch(s1[31:26], s1[5:0])
                  && !is_serial(s0[31:26], s0[5:0])
                  && !is_serial(s1[31:26], s1[5:0])
                  && !(s0[31] && s1[31])
                  && !hazard;
    end
`else
    assign pair_ok = 1'b0;
`endif

    assign head1      = head_q + PTR_W'(1);
    assign in_ready   = count_q < CNT_W'(DEPTH);
    assign out0_valid = count_q != '0;
    assign out1_valid = pair_ok;
    assign out0_inst  = inst_q[head_q];
    assign out0_pc    = pc_q[head_q];
    assign out1_inst  = inst_q[head1];
    assign out1_pc    = pc_q[head1];
    assign count      = count_q;

    // Take is clamped to what is actually presented, so take=2 with only
    // one valid slot (or single-issue build) consumes one entry.
    assign avail    = {1'b0, out0_valid} + {1'b0, out1_valid};
    assign take_eff = (out_take < avail) ? out_take : avail;
    assign wr_en    = in_valid & in_ready;

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (wr_en) begin
                inst_d[tail_q] = in_inst;
                pc_d[tail_q]   = in_pc;
                tail_d         = tail_q + PTR_W'(1);
            end
            head_d  = head_q + PTR_W'(take_eff);
            count_d = count_q + CNT_W'(wr_en) - CNT_W'(take_eff);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_inst_issue_buffer.sv
module tb_inst_issue_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_inst;
    logic [31:0]      in_pc;
    logic             flush;
    logic             out0_valid;
    logic [31:0]      out0_inst;
    logic [31:0]      out0_pc;
    logic             out1_valid;
    logic [31:0]      out1_inst;
    logic [31:0]      out1_pc;
    logic [1:0]       out_take;
    logic [CNT_W-1:0] count;

    inst_issue_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .out0_valid(out0_valid), .out0_inst(out0_inst), .out0_pc(out0_pc),
        .out1_valid(out1_valid), .out1_inst(out1_inst), .out1_pc(out1_pc),
        .out_take(out_take), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] popped[$];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference pre-decode, written from the ISA rules ----------------
    function automatic bit m_branch(logic [31:0] i);
        int op = int'(i[31:26]);
        int fn = int'(i[5:0]);
        return (op >= 1 && op <= 7) || (op == 0 && (fn == 8 || fn == 9));
    endfunction

    function automatic int m_dest(logic [31:0] i);
        int op = int'(i[31:26]);
        if (op == 0) return int'(i[15:11]);
        if (op == 3) return 31;
        if (op == 1 && i[20]) return 31;
        if (op / 8 == 1 || op / 8 == 4) return int'(i[20:16]);
        return 0;
    endfunction

    function automatic bit m_serial(logic [31:0] i);
        int op = int'(i[31:26]);
        int fn = int'(i[5:0]);
        if (op == 16 || op == 17 || op == 19 || op == 28 || op == 47) return 1'b1;
        if (op != 0) return 1'b0;
        return (fn == 12 || fn == 13 || fn == 15 || (fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27));
    endfunction

    function automatic bit m_pairable(logic [31:0] a, logic [31:0] b);
        int da = m_dest(a);
        bit reg_ok = (da == 0) ||
                     (da != int'(b[25:21]) && da != int'(b[20:16]) && da != m_dest(b));
        return !m_branch(b) && !m_serial(a) && !m_serial(b) && !(a[31] && b[31]) && reg_ok;
    endfunction

    function automatic bit exp_out1_valid();
`ifdef INST_ISSUE_BUFFER_DUAL_ISSUE_EN
        return (q.size() >= 2) && m_pairable(q[0].inst, q[1].inst);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".count"},      32'(count),      32'(q.size()));
        chk({tag, ".in_ready"},   32'(in_ready),   32'(q.size() < DEPTH));
        chk({tag, ".out0_valid"}, 32'(out0_valid), 32'(q.size() > 0));
        chk({tag, ".out1_valid"}, 32'(out1_valid), 32'(exp_out1_valid()));
        if (q.size() > 0) begin
            chk({tag, ".out0_inst"}, out0_inst, q[0].inst);
            chk({tag, ".out0_pc"},   out0_pc,   q[0].pc);
        end
        if (q.size() > 1) begin
            chk({tag, ".out1_inst"}, out1_inst, q[1].inst);
            chk({tag, ".out1_pc"},   out1_pc,   q[1].pc);
        end
    endtask

    // One clock: drive, update the model with the pre-edge state, check after the edge.
    task automatic step(input string tag, input bit v, input logic [31:0] inst,
                        input logic [31:0] pc, input int take, input bit fl);
        bit   acc;
        int   avail;
        int   eff;
        ent_t e;
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
        out_take = 2'(take);
        flush    = fl;
        acc   = v && (q.size() < DEPTH);
        avail = int'(q.size() > 0) + int'(exp_out1_valid());
        eff   = (take < avail) ? take : avail;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            for (int k = 0; k < eff; k++) popped.push_back(q.pop_front().pc);
            if (acc) begin
                e.inst = inst;
                e.pc   = pc;
                q.push_back(e);
            end
        end
        in_valid = 1'b0;
        out_take = 2'd0;
        flush    = 1'b0;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] addu(int rd, int rs, int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h21};
    endfunction

    function automatic logic [31:0] rand_inst();
        int ops[13] = '{0, 0, 0, 9, 35, 43, 4, 2, 3, 1, 16, 15, 8};
        int fns[8]  = '{33, 35, 8, 12, 0, 16, 24, 42};
        logic [5:0] op = 6'(ops[$urandom_range(0, 12)]);
        logic [5:0] fn = 6'(fns[$urandom_range(0, 7)]);
        logic [4:0] rs = 5'($urandom_range(0, 7));
        logic [4:0] rt = 5'($urandom_range(0, 7));
        logic [4:0] rd = 5'($urandom_range(0, 7));
        if (op == 6'd1 && $urandom_range(0, 1) == 1) rt[4] = 1'b1;
        return {op, rs, rt, rd, 5'h00, fn};
    endfunction

    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic [31:0] pa [5];
    logic [31:0] pb [5];
    bit          pexp [5];
    int          k;
    int          take_sel;
    int          cyc;
    int          cnt_before;
    logic [31:0] pc_ctr;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_inst  = '0;
        in_pc    = '0;
        flush    = 1'b0;
        out_take = 2'd0;
        #12;
        chk("reset.count",      32'(count),      32'd0);
        chk("reset.in_ready",   32'(in_ready),   32'd1);
        chk("reset.out0_valid", 32'(out0_valid), 32'd0);
        chk("reset.out1_valid", 32'(out1_valid), 32'd0);
        chk("reset.out0_inst",  out0_inst, 32'd0);
        chk("reset.out0_pc",    out0_pc,   32'd0);
        chk("reset.out1_inst",  out1_inst, 32'd0);
        chk("reset.out1_pc",    out1_pc,   32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset mid-stream with five entries held.
        for (int i = 0; i < 5; i++) step("midfill", 1'b1, addu(i + 1, 0, 0), 32'h1000 + 32'(4 * i), 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.count",      32'(count),      32'd0);
        chk("midreset.out0_valid", 32'(out0_valid), 32'd0);
        chk("midreset.in_ready",   32'(in_ready),   32'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        step("postreset", 1'b1, addu(9, 0, 0), 32'h2000, 0, 1'b0);
        chk("postreset.out0_pc", out0_pc, 32'h2000);

        // Fill to DEPTH with no take; ninth beat must be refused.
        step("fill.flush", 1'b0, NOP, 32'h0, 0, 1'b1);
        for (int i = 0; i < 8; i++) step("fill", 1'b1, NOP, 32'h3000 + 32'(4 * i), 0, 1'b0);
        chk("fill.in_ready_full", 32'(in_ready), 32'd0);
        step("fill.ninth", 1'b1, NOP, 32'h3FFC, 0, 1'b0);
        step("fill.take1", 1'b0, NOP, 32'h0, 1, 1'b0);
        chk("fill.count7",   32'(count),    32'd7);
        chk("fill.ready7",   32'(in_ready), 32'd1);

        // Wrap-around with alternating take 1/2.
        step("wrap.flush", 1'b0, NOP, 32'h0, 0, 1'b1);
        popped.delete();
        k        = 0;
        take_sel = 1;
        cyc      = 0;
        while (popped.size() < 20 && cyc < 100) begin
            bit acc;
            acc = (k < 20) && (q.size() < DEPTH);
            step("wrap", k < 20, NOP, BASE + 32'(4 * k), take_sel, 1'b0);
            if (acc) k++;
            take_sel = (take_sel == 1) ? 2 : 1;
            cyc++;
        end
        chk("wrap.popped", 32'(popped.size()), 32'd20);
        for (int i = 0; i < 20 && i < popped.size(); i++)
            chk("wrap.pc_seq", popped[i], BASE + 32'(4 * i));

        // Pairing table.
        pa[0] = addu(3, 1, 2); pb[0] = addu(4, 3, 5);                 pexp[0] = 1'b0;
        pa[1] = addu(3, 1, 2); pb[1] = addu(4, 6, 5);                 pexp[1] = 1'b1;
        pa[2] = {6'h23, 5'd9, 5'd8, 16'h0000};
        pb[2] = {6'h2b, 5'd11, 5'd10, 16'h0004};                      pexp[2] = 1'b0;
        pa[3] = {6'h04, 5'd1, 5'd2, 16'h0010}; pb[3] = addu(4, 6, 5); pexp[3] = 1'b1;
        pa[4] = addu(3, 1, 2); pb[4] = {6'h04, 5'd1, 5'd2, 16'h0010}; pexp[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("pair.flush", 1'b0, NOP, 32'h0, 0, 1'b1);
            step("pair.a", 1'b1, pa[i], 32'h4000, 0, 1'b0);
            step("pair.b", 1'b1, pb[i], 32'h4004, 0, 1'b0);
`ifdef INST_ISSUE_BUFFER_DUAL_ISSUE_EN
            chk("pair.table", 32'(out1_valid), 32'(pexp[i]));
`else
            chk("pair.table", 32'(out1_valid), 32'(pexp[i] & 1'b0));
`endif
        end

        // Flush overrides write and take.
        step("flush.clr", 1'b0, NOP, 32'h0, 0, 1'b1);
        for (int i = 0; i < 6; i++) step("flush.fill", 1'b1, NOP, 32'h100 + 32'(4 * i), 0, 1'b0);
        step("flush.hit", 1'b1, NOP, 32'hDEAD_BEE0, 2, 1'b1);
        chk("flush.count", 32'(count),      32'd0);
        chk("flush.v0",    32'(out0_valid), 32'd0);
        chk("flush.v1",    32'(out1_valid), 32'd0);
        for (int i = 0; i < 3; i++) step("flush.idle", 1'b0, NOP, 32'h0, 0, 1'b0);
        step("flush.next", 1'b1, NOP, 32'h200, 0, 1'b0);
        chk("flush.next_pc", out0_pc, 32'h200);

        // Pairable pair with take=2.
        step("take2.flush", 1'b0, NOP, 32'h0, 0, 1'b1);
        step("take2.a", 1'b1, addu(3, 1, 2), 32'h500, 0, 1'b0);
        step("take2.b", 1'b1, addu(4, 6, 5), 32'h504, 0, 1'b0);
        cnt_before = int'(count);
        step("take2.go", 1'b0, NOP, 32'h0, 2, 1'b0);
`ifdef INST_ISSUE_BUFFER_DUAL_ISSUE_EN
        chk("take2.drop", 32'(cnt_before - int'(count)), 32'd2);
`else
        chk("take2.drop", 32'(cnt_before - int'(count)), 32'd1);
`endif

        // Randomized traffic against the model.
        step("rand.flush", 1'b0, NOP, 32'h0, 0, 1'b1);
        pc_ctr = 32'h8000_0000;
        for (int i = 0; i < 400; i++) begin
            step("rand", $urandom_range(0, 3) != 0, rand_inst(), pc_ctr,
                 int'($urandom_range(0, 2)), $urandom_range(0, 39) == 0);
            pc_ctr = pc_ctr + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_issue_buffer.md
# inst_issue_buffer

Parametrised instruction buffer between IF and ID that replaces the direct fetch-to-decode handoff. It queues fetched instruction/PC pairs in a circular buffer. It presents the two oldest entries to decode and pre-decodes them to decide whether the pair may issue together in one cycle. Dual issue is a compile-time option; with it off the block is a plain single-issue skid FIFO.

## Interface
- DEPTH, 8, entry count; power of two, ≥4.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  buffer can accept; equals count < DEPTH.
- in_inst  in  32  instruction word.
- in_pc  in  32  instruction address.
- flush  in  1  discard all contents (exception, eret, mispredict).
- out0_valid  out  1  oldest entry present.
- out0_inst, out0_pc  out  32 each  oldest entry.
- out1_valid  out  1  second entry present and pairable with out0.
- out1_inst, out1_pc  out  32 each  second-oldest entry.
- out_take  in  2  entries consumed by decode this cycle: 0, 1 or 2.
- count  out  CNT_W  current occupancy.

## Operation
- Storage: DEPTH-entry register array, head/tail pointers of $clog2(DEPTH) bits with natural wrap, plus a CNT_W occupancy counter.
- Write: accepted when in_valid & in_ready; stored at tail; tail +1.
- Read: out0 and out1 are the entries at head and head+1 (mod DEPTH); head += effective take.
- Effective take: min(out_take, out0_valid + out1_valid). Take 2 with out1_valid=0 consumes one entry. Take ≥1 with count 0 consumes nothing.
- count_next = count + write − effective take.
  - Simultaneous write and take on a full buffer is impossible, because in_ready is already 0.
  - Simultaneous write and take on an empty buffer stores the entry and consumes nothing.
- flush:
  - Overrides write and take in the same cycle.
  - Next cycle: count=0, head=tail=0, both valids 0.
  - The in_valid beat in the flush cycle is dropped.
- Pre-decode per slot:
  - branch/jump: opcode 000010, 000011, 000100–000111, 000001 (REGIMM), or opcode 0 with func 001000/001001.
  - dest:
    - rd for opcode 0;
    - 31 for jal, or REGIMM with rt[4]=1;
    - rt for opcodes 001xxx and 100xxx;
    - otherwise none (dest 0 ⇒ none).
  - mem: opcode[5]=1.
  - serialising: opcodes 010000, 010001, 010011, 011100, 101111, or opcode 0 with func in {001100, 001101, 001111, 010000–010011, 011000–011011}.
- out1_valid = count≥2 & pairing permitted. Pairing permitted only if all hold:
  - slot1 is not branch/jump;
  - neither slot is serialising;
  - not both slots are mem;
  - slot0 dest is none, or differs from slot1 rs, rt and dest.
- A branch in slot0 with its delay slot in slot1 may pair when the rules above hold.

## Timing
- Reset (async, immediate): head=tail=0, count=0, in_ready=1, out0_valid=out1_valid=0, out data 0.
- Outputs are combinational from registered state only. No fall-through: an entry written in cycle N appears on out0 at N+1 at the earliest.
- in_ready depends only on count, never on out_take. A full buffer stalls fetch for one cycle even when decode is consuming.
- Pairing logic is purely combinational on the two head entries; it adds no latency.
- Sustained throughput is 1 write/cycle. Drain rate is up to 2/cycle.

## Configuration
- INST_ISSUE_BUFFER_DUAL_ISSUE_EN defined: pre-decode and pairing logic are built; out1_valid follows the rules above.
- Undefined:
  - out1_valid tied 0 and no pre-decode logic is built.
  - out_take=2 behaves as 1.
  - out1_inst/out1_pc still show entry head+1, for debug.

## Test plan
- Reset mid-stream with count=5: on assertion, count=0, out0_valid=0, in_ready=1. The first write after release appears on out0 one cycle later.
- Fill DEPTH=8 with take=0: in_ready drops after the 8th write and a 9th beat is not accepted. Then take=1 for one cycle: count=7 and in_ready=1 the following cycle.
- Wrap-around: 20 sequential PCs 0xBFC00000+4k with alternating take 1/2. out0_pc sequence is strictly +4 with no gaps or duplicates.
- Pairing: addu $3,$1,$2 then addu $4,$3,$5 ⇒ out1_valid=0. addu $3,$1,$2 then addu $4,$6,$5 ⇒ out1_valid=1. lw then sw ⇒ 0. beq then addu delay slot ⇒ 1. addu then beq ⇒ 0.
- Flush with count=6, in_valid=1 and out_take=2 in the same cycle: next cycle count=0, both valids 0, and the flushed beat never appears.
- Macro undefined: pairable pair present with out_take=2 ⇒ out1_valid=0 and count drops by exactly 1.
